prog_host: RTL and testbench

Host-side sequencer that drives the `top_level` processor's `req`/`done` start protocol. It sits between an external byte stream and the processor, and runs one job at a time:
- preloads the processor's data memory through a memory write port;
- pulses `req` to start the program, then waits for `done`;
- drains a result window of data memory out as a valid/ready stream.

It is the initiator for the processor's responder-side handshake, shared by the testbench and the FPGA wrapper.

---
 rtl/prog_host_pkg.sv | 16 +
 rtl/prog_host_if.sv | 51 +++++
 rtl/prog_host_watchdog.sv | 32 +++
 rtl/prog_host.sv | 188 ++++++++++++++++++
 tb/tb_prog_host.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_host_pkg.sv
// prog_host_pkg: shared types and constants for the prog_host sequencer.
//   host_state_t : sequencer state encoding (IDLE, LOAD, REQ, RUN, DRAIN)
//   RUNCNT_W     : width of the run_cycles counter
package prog_host_pkg;

  localparam int RUNCNT_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    REQ   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } host_state_t;

endpackage

// File: rtl/prog_host_if.sv
// prog_host_if: bundles the prog_host bus signals.
//   ld_*  : preload stream (valid/ready) into data memory
//   mem_* : data-memory port (write strobe, address, write data, comb. read data)
//   req/done : processor start/finish handshake
//   res_* : result stream (valid/ready) drained from data memory
// Modports: master = prog_host side, slave = environment side.
interface prog_host_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  logic          req;
  logic          done;

  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;
  logic          res_last;

  modport master (
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    output mem_wr_en, mem_addr, mem_wr_data,
    input  mem_rd_data,
    output req,
    input  done,
    output res_valid, res_addr, res_data, res_last,
    input  res_ready
  );

  modport slave (
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    input  mem_wr_en, mem_addr, mem_wr_data,
    output mem_rd_data,
    input  req,
    output done,
    input  res_valid, res_addr, res_data, res_last,
    output res_ready
  );
endinterface

// File: rtl/prog_host_watchdog.sv
// host_watchdog: counts cycles while enabled and flags expiry.
//   clk, reset : clock, synchronous active-high reset
//   enable     : count this cycle
//   clear      : restart the count from zero
//   limit      : number of enabled cycles allowed
//   expire     : high during the limit-th enabled cycle (never when limit = 0)
module host_watchdog #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // cnt_reg holds the number of enabled cycles already completed, so the
  // limit-th cycle is the one where it reads limit-1.
  assign expire = enable && (limit != '0) && (cnt_reg == limit - CNT_W'(1));

endmodule

// File: rtl/prog_host.sv
// prog_host: host-side job sequencer for the processor req/done protocol.
// One job = preload LOAD_N beats into data memory, pulse req, wait for done,
// then stream DRAIN_N result bytes starting at DRAIN_BASE.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a job (sampled only in IDLE)
//   bus        : prog_host_if.master (preload, memory, req/done, results)
//   busy       : high in every state but IDLE
//   fin        : one-cycle job-complete pulse
//   timeout    : sticky, last job aborted by watchdog
//   run_cycles : RUN-state dwell of the last job, saturating
// Build option: define PROG_HOST_WATCHDOG_EN to abort RUN after TIMEOUT cycles.
module prog_host
  import prog_host_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int LOAD_N     = 64,
  parameter int DRAIN_BASE = 0,
  parameter int DRAIN_N    = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  prog_host_if.master         bus,
  output logic                busy,
  output logic                fin,
  output logic                timeout,
  output logic [RUNCNT_W-1:0] run_cycles
);

  // Beat-index constants; each is only compared in the branch where the
  // corresponding count is at least the value implied.
  localparam logic [15:0] LD_LAST = 16'(LOAD_N - 1);
  localparam logic [15:0] DR_PEN  = 16'(DRAIN_N - 2);

  host_state_t          state_reg;
  logic [15:0]          ld_cnt_reg;
  logic [15:0]          dr_cnt_reg;
  logic [AW-1:0]        ptr_reg;
  logic                 ld_ready_reg;
  logic                 req_reg;
  logic                 res_valid_reg;
  logic                 res_last_reg;
  logic                 busy_reg;
  logic                 fin_reg;
  logic                 timeout_reg;
  logic [RUNCNT_W-1:0]  run_cycles_reg;
  logic                 wd_expire;

`ifdef PROG_HOST_WATCHDOG_EN
  host_watchdog #(
    .CNT_W (32)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .enable (state_reg == RUN),
    .clear  (state_reg != RUN),
    .limit  (32'(TIMEOUT)),
    .expire (wd_expire)
  );
`else
  // Without the watchdog RUN waits for done forever; TIMEOUT has no effect.
  localparam int timeout_unused = TIMEOUT;
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      ld_cnt_reg     <= '0;
      dr_cnt_reg     <= '0;
      ptr_reg        <= '0;
      ld_ready_reg   <= 1'b0;
      req_reg        <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_last_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      fin_reg        <= 1'b0;
      timeout_reg    <= 1'b0;
      run_cycles_reg <= '0;
    end else begin
      fin_reg <= 1'b0;
      req_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            ld_cnt_reg     <= '0;
            run_cycles_reg <= '0;
            timeout_reg    <= 1'b0;
            busy_reg       <= 1'b1;
            if (LOAD_N == 0) begin
              state_reg <= REQ;
              req_reg   <= 1'b1;
            end else begin
              state_reg    <= LOAD;
              ld_ready_reg <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.ld_valid) begin
            ld_cnt_reg <= ld_cnt_reg + 16'd1;
            if (ld_cnt_reg == LD_LAST) begin
              state_reg    <= REQ;
              ld_ready_reg <= 1'b0;
              req_reg      <= 1'b1;
            end
          end
        end
        REQ: begin
          // done is deliberately not looked at here.
          state_reg <= RUN;
        end
        RUN: begin
          if (run_cycles_reg != '1) begin
            run_cycles_reg <= run_cycles_reg + RUNCNT_W'(1);
          end
          if (bus.done) begin
            if (DRAIN_N == 0) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              fin_reg   <= 1'b1;
            end else begin
              state_reg     <= DRAIN;
              ptr_reg       <= AW'(DRAIN_BASE);
              dr_cnt_reg    <= '0;
              res_valid_reg <= 1'b1;
              res_last_reg  <= (DRAIN_N == 1);
            end
          end else if (wd_expire) begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            fin_reg     <= 1'b1;
            timeout_reg <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.res_ready) begin
            if (res_last_reg) begin
              state_reg     <= IDLE;
              busy_reg      <= 1'b0;
              fin_reg       <= 1'b1;
              res_valid_reg <= 1'b0;
              res_last_reg  <= 1'b0;
            end else begin
              ptr_reg      <= ptr_reg + AW'(1);
              dr_cnt_reg   <= dr_cnt_reg + 16'd1;
              // Next beat is the last one when the beat just taken was DRAIN_N-2.
              res_last_reg <= (dr_cnt_reg == DR_PEN);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Preload writes go straight through to memory in the accepting cycle.
  assign bus.ld_ready    = ld_ready_reg;
  assign bus.mem_wr_en   = ld_ready_reg & bus.ld_valid;
  assign bus.mem_wr_data = bus.mem_wr_en ? bus.ld_data : '0;

  always_comb begin
    bus.mem_addr = '0;
    if (bus.mem_wr_en) begin
      bus.mem_addr = bus.ld_addr;
    end else if (res_valid_reg) begin
      bus.mem_addr = ptr_reg;
    end
  end

  // Result fields come from the held pointer, so they stay put under backpressure.
  assign bus.req       = req_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_last  = res_last_reg;
  assign bus.res_addr  = res_valid_reg ? ptr_reg : '0;
  assign bus.res_data  = res_valid_reg ? bus.mem_rd_data : '0;

  assign busy       = busy_reg;
  assign fin        = fin_reg;
  assign timeout    = timeout_reg;
  assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_prog_host.sv
// tb_prog_host: directed bench for prog_host.
// Instance A: LOAD_N=2, DRAIN_BASE=0x00, DRAIN_N=2, TIMEOUT=8.
// Instance B: LOAD_N=0, DRAIN_BASE=0xFE, DRAIN_N=4 (skip-load and wrap).
// Watchdog checks are included when PROG_HOST_WATCHDOG_EN is defined.
module tb_prog_host;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        busy_a, fin_a, to_a, busy_b, fin_b, to_b;
  logic [15:0] rc_a, rc_b;

  int n_cmp = 0;
  int n_err = 0;
  int fin_cnt_a = 0;
  int req_cnt_a = 0;
  int fin_cnt_b = 0;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  prog_host_if #(.AW(8), .DW(8)) bus_a ();
  prog_host_if #(.AW(8), .DW(8)) bus_b ();

  prog_host #(
    .AW(8), .DW(8), .LOAD_N(2), .DRAIN_BASE(0), .DRAIN_N(2), .TIMEOUT(8)
  ) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
    .busy(busy_a), .fin(fin_a), .timeout(to_a), .run_cycles(rc_a)
  );

  prog_host #(
    .AW(8), .DW(8), .LOAD_N(0), .DRAIN_BASE(8'hFE), .DRAIN_N(4), .TIMEOUT(8)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
    .busy(busy_b), .fin(fin_b), .timeout(to_b), .run_cycles(rc_b)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'h3C;
  endfunction

  // Data memories: pattern-filled on reset, written by the DUT strobes.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= pat(8'(i));
        mem_b[i] <= pat(8'(i));
      end
    end else begin
      if (bus_a.mem_wr_en) mem_a[bus_a.mem_addr] <= bus_a.mem_wr_data;
      if (bus_b.mem_wr_en) mem_b[bus_b.mem_addr] <= bus_b.mem_wr_data;
    end
  end

  assign bus_a.mem_rd_data = mem_a[bus_a.mem_addr];
  assign bus_b.mem_rd_data = mem_b[bus_b.mem_addr];

  always @(negedge clk) begin
    if (fin_a)     fin_cnt_a <= fin_cnt_a + 1;
    if (bus_a.req) req_cnt_a <= req_cnt_a + 1;
    if (fin_b)     fin_cnt_b <= fin_cnt_b + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a job on A, load (0x10<-AA),(0x11<-55), raise done dly cycles after
  // req; returns in the first DRAIN cycle.
  task automatic to_drain_a(input int dly);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    bus_a.ld_valid = 1'b1; bus_a.ld_addr = 8'h10; bus_a.ld_data = 8'hAA;
    tick();
    bus_a.ld_addr = 8'h11; bus_a.ld_data = 8'h55;
    tick();
    bus_a.ld_valid = 1'b0;
    repeat (dly) tick();
    bus_a.done = 1'b1;
    tick();
    bus_a.done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_tb: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus_a.ld_valid = 1'b0; bus_a.ld_addr = '0; bus_a.ld_data = '0;
    bus_a.done = 1'b0; bus_a.res_ready = 1'b0;
    bus_b.ld_valid = 1'b0; bus_b.ld_addr = '0; bus_b.ld_data = '0;
    bus_b.done = 1'b0; bus_b.res_ready = 1'b0;

    // ---- reset state ----
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("rst_busy",   32'(busy_a), 32'd0);
    check_eq("rst_ldrdy",  32'(bus_a.ld_ready), 32'd0);
    check_eq("rst_req",    32'(bus_a.req), 32'd0);
    check_eq("rst_fin",    32'(fin_a), 32'd0);
    check_eq("rst_to",     32'(to_a), 32'd0);
    check_eq("rst_rc",     32'(rc_a), 32'd0);
    check_eq("rst_resv",   32'(bus_a.res_valid), 32'd0);
    check_eq("rst_wren",   32'(bus_a.mem_wr_en), 32'd0);
    check_eq("rst_b_busy", 32'(busy_b), 32'd0);

    // ---- basic job with ignored done and backpressure ----
    bus_a.done = 1'b1;                       // done in IDLE
    tick();
    check_eq("idle_done_busy", 32'(busy_a), 32'd0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_eq("load_ldrdy", 32'(bus_a.ld_ready), 32'd1);
    check_eq("load_busy",  32'(busy_a), 32'd1);
    bus_a.ld_valid = 1'b1; bus_a.ld_addr = 8'h10; bus_a.ld_data = 8'hAA;
    #1;
    check_eq("load_wren",  32'(bus_a.mem_wr_en), 32'd1);
    check_eq("load_maddr", 32'(bus_a.mem_addr), 32'h10);
    check_eq("load_wdata", 32'(bus_a.mem_wr_data), 32'hAA);
    tick();
    check_eq("load_done_ign", 32'(bus_a.ld_ready), 32'd1);
    bus_a.ld_addr = 8'h11; bus_a.ld_data = 8'h55;
    tick();                                  // REQ (cycle r), done still high
    bus_a.ld_valid = 1'b0;
    #1;
    check_eq("req_pulse", 32'(bus_a.req), 32'd1);
    check_eq("req_ldrdy", 32'(bus_a.ld_ready), 32'd0);
    check_eq("req_wren",  32'(bus_a.mem_wr_en), 32'd0);
    tick();                                  // r+1, RUN
    bus_a.done = 1'b0;
    check_eq("run_req_drop", 32'(bus_a.req), 32'd0);
    check_eq("run_resv",     32'(bus_a.res_valid), 32'd0);
    check_eq("mem_10", 32'(mem_a[8'h10]), 32'hAA);
    check_eq("mem_11", 32'(mem_a[8'h11]), 32'h55);
    start_a = 1'b1;                          // start in RUN
    tick();                                  // r+2
    start_a = 1'b0;
    tick(); tick(); tick();                  // r+5
    bus_a.done = 1'b1;
    tick();                                  // r+6, DRAIN
    bus_a.done = 1'b0;
    check_eq("run_cycles", 32'(rc_a), 32'd5);
    check_eq("dr0_valid",  32'(bus_a.res_valid), 32'd1);
    check_eq("dr0_addr",   32'(bus_a.res_addr), 32'h00);
    check_eq("dr0_data",   32'(bus_a.res_data), 32'h3C);
    check_eq("dr0_last",   32'(bus_a.res_last), 32'd0);
    bus_a.res_ready = 1'b1;
    tick();
    bus_a.res_ready = 1'b0;
    check_eq("dr1_addr", 32'(bus_a.res_addr), 32'h01);
    check_eq("dr1_data", 32'(bus_a.res_data), 32'h3D);
    check_eq("dr1_last", 32'(bus_a.res_last), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_addr", 32'(bus_a.res_addr), 32'h01);
      check_eq("bp_data", 32'(bus_a.res_data), 32'h3D);
      check_eq("bp_fin",  32'(fin_a), 32'd0);
    end
    bus_a.res_ready = 1'b1;
    tick();
    bus_a.res_ready = 1'b0;
    check_eq("fin_pulse",  32'(fin_a), 32'd1);
    check_eq("fin_busy",   32'(busy_a), 32'd0);
    check_eq("fin_resv",   32'(bus_a.res_valid), 32'd0);
    tick();
    check_eq("fin_drop",   32'(fin_a), 32'd0);
    check_eq("req_count",  32'(req_cnt_a), 32'd1);
    check_eq("fin_count",  32'(fin_cnt_a), 32'd1);
    check_eq("rc_held",    32'(rc_a), 32'd5);

    // ---- reset mid-drain, then a clean job ----
    to_drain_a(2);
    check_eq("pre_rst_resv", 32'(bus_a.res_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mrst_busy",  32'(busy_a), 32'd0);
    check_eq("mrst_resv",  32'(bus_a.res_valid), 32'd0);
    check_eq("mrst_raddr", 32'(bus_a.res_addr), 32'd0);
    check_eq("mrst_rc",    32'(rc_a), 32'd0);
    check_eq("mrst_fin",   32'(fin_a), 32'd0);
    tick();
    check_eq("mrst_nofin", 32'(fin_cnt_a), 32'd1);
    to_drain_a(3);
    check_eq("job2_rc",    32'(rc_a), 32'd3);
    check_eq("job2_addr0", 32'(bus_a.res_addr), 32'h00);
    bus_a.res_ready = 1'b1;
    tick();
    check_eq("job2_addr1", 32'(bus_a.res_addr), 32'h01);
    check_eq("job2_last",  32'(bus_a.res_last), 32'd1);
    tick();
    bus_a.res_ready = 1'b0;
    check_eq("job2_fin",   32'(fin_a), 32'd1);

    // ---- instance B: skip-load and address wrap ----
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check_eq("b_req",   32'(bus_b.req), 32'd1);
    check_eq("b_ldrdy", 32'(bus_b.ld_ready), 32'd0);
    tick();
    bus_b.done = 1'b1;
    tick();
    bus_b.done = 1'b0;
    check_eq("b_rc", 32'(rc_b), 32'd1);
    bus_b.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ea;
      ea = 8'hFE + 8'(i);
      check_eq("b_addr", 32'(bus_b.res_addr), 32'(ea));
      check_eq("b_data", 32'(bus_b.res_data), 32'(pat(ea)));
      check_eq("b_last", 32'(bus_b.res_last), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    bus_b.res_ready = 1'b0;
    check_eq("b_fin",  32'(fin_b), 32'd1);
    check_eq("b_busy", 32'(busy_b), 32'd0);
    check_eq("b_to",   32'(to_b), 32'd0);

`ifdef PROG_HOST_WATCHDOG_EN
    // ---- watchdog abort after 8 RUN cycles ----
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    bus_a.ld_valid = 1'b1; bus_a.ld_addr = 8'h20; bus_a.ld_data = 8'h01;
    tick();
    bus_a.ld_addr = 8'h21;
    tick();                                  // REQ (r)
    bus_a.ld_valid = 1'b0;
    repeat (8) tick();                       // r+8, last RUN cycle
    check_eq("wd_busy", 32'(busy_a), 32'd1);
    check_eq("wd_early_fin", 32'(fin_a), 32'd0);
    tick();                                  // r+9
    check_eq("wd_fin",  32'(fin_a), 32'd1);
    check_eq("wd_to",   32'(to_a), 32'd1);
    check_eq("wd_rc",   32'(rc_a), 32'd8);
    check_eq("wd_resv", 32'(bus_a.res_valid), 32'd0);
    tick();
    check_eq("wd_sticky", 32'(to_a), 32'd1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_eq("wd_clear", 32'(to_a), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
